// File: rtl/debounced_logic_gate.sv
// Debounced pushbutton logic gate.
// Synchronises and debounces NUM_BTNS active-low buttons, then combines the
// debounced pressed states with a run-time selectable function. The function
// drives a registered LED and a one-cycle pulse on the LED's rising edge.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_btn    asynchronous active-low reset
//   btn_n      raw button pins, asynchronous, 0 = pressed
//   mode       gate function: 0 AND, 1 OR, 2 XOR (odd parity), 3 NAND
//   btn_state  debounced pressed state, active high
//   led_0      registered gate result
//   led_rise   one-cycle pulse when led_0 goes 0 -> 1
module debounced_logic_gate #(
    parameter int unsigned NUM_BTNS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic                clk,
    input  logic                rst_btn,
    input  logic [NUM_BTNS-1:0] btn_n,
    input  logic [1:0]          mode,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic                led_0,
    output logic                led_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } mode_e;

    logic [NUM_BTNS-1:0] sync_1;
    logic [NUM_BTNS-1:0] sync_2;
    logic [CNT_W-1:0]    cnt      [NUM_BTNS];
    logic [CNT_W-1:0]    cnt_next [NUM_BTNS];
    logic [NUM_BTNS-1:0] state_next;
    logic                gate_c;
    mode_e               mode_sel;

    // Two-flop synchroniser; resets to the released level (pins high).
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    // Per-channel debounce: a sample matching the accepted state clears the
    // count, so any bounce restarts the wait. The terminal compare stops the
    // counter before it can reach its wrap point.
    always_comb begin
        state_next = btn_state;
        for (int i = 0; i < int'(NUM_BTNS); i++) begin
            cnt_next[i] = cnt[i];
            if (~sync_2[i] == btn_state[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                state_next[i] = ~btn_state[i];
                cnt_next[i]   = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Debounce state and counter registers.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            btn_state <= '0;
            for (int i = 0; i < int'(NUM_BTNS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_state <= state_next;
            for (int i = 0; i < int'(NUM_BTNS); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Gate function over the current debounced state.
    assign mode_sel = mode_e'(mode);

    always_comb begin
        gate_c = 1'b0;
        case (mode_sel)
            MODE_AND:  gate_c = &btn_state;
            MODE_OR:   gate_c = |btn_state;
            MODE_XOR:  gate_c = ^btn_state;
            MODE_NAND: gate_c = ~(&btn_state);
            default:   gate_c = 1'b0;
        endcase
    end

    // LED register; the pulse compares the new value against the old LED.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            led_0    <= 1'b0;
            led_rise <= 1'b0;
        end else begin
            led_0    <= gate_c;
            led_rise <= gate_c & ~led_0;
        end
    end

endmodule

// File: tb/tb_debounced_logic_gate.sv
// Scoreboard bench for debounced_logic_gate: one instance with 2 buttons and
// a 4-sample debounce, one with 3 buttons and a 1-sample debounce. A
// reference model pushes expected outputs each edge; a monitor pops and
// compares on the falling edge.
module tb_debounced_logic_gate;

    localparam int unsigned N2 = 2;
    localparam int unsigned D2 = 4;
    localparam int unsigned N3 = 3;
    localparam int unsigned D3 = 1;

    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic [1:0] btn_n2 = 2'b00;
    logic [1:0] mode2 = 2'd0;
    logic [1:0] st2;
    logic       led2;
    logic       rise2;
    logic [2:0] btn_n3 = 3'b111;
    logic [1:0] mode3 = 2'd2;
    logic [2:0] st3;
    logic       led3;
    logic       rise3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounced_logic_gate #(.NUM_BTNS(N2), .DEBOUNCE_CYCLES(D2)) u_dut2 (
        .clk(clk), .rst_btn(rst_btn), .btn_n(btn_n2), .mode(mode2),
        .btn_state(st2), .led_0(led2), .led_rise(rise2)
    );

    debounced_logic_gate #(.NUM_BTNS(N3), .DEBOUNCE_CYCLES(D3)) u_dut3 (
        .clk(clk), .rst_btn(rst_btn), .btn_n(btn_n3), .mode(mode3),
        .btn_state(st3), .led_0(led3), .led_rise(rise3)
    );

    // Model state: accepted levels, LED, pulse, run length of samples that
    // disagree with the accepted level, and the raw pins seen one and two
    // edges ago.
    typedef struct packed {
        logic [2:0]       st;
        logic             led;
        logic             rise;
        logic [2:0][15:0] run;
        logic [2:0]       h1;
        logic [2:0]       h2;
    } model_t;

    model_t     m2;
    model_t     m3;
    logic [4:0] q2[$];
    logic [4:0] q3[$];

    function automatic model_t model_reset();
        model_t m;
        m    = '0;
        m.h1 = 3'b111;
        m.h2 = 3'b111;
        return m;
    endfunction

    function automatic model_t model_step(model_t mi, int n, int d,
                                          logic [2:0] bn, logic [1:0] md);
        model_t m;
        int     ones;
        logic   f;
        m    = mi;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(m.st[i]);
        case (md)
            2'd0:    f = (ones == n);
            2'd1:    f = (ones > 0);
            2'd2:    f = ((ones % 2) == 1);
            default: f = (ones != n);
        endcase
        m.rise = f & ~m.led;
        m.led  = f;
        for (int i = 0; i < n; i++) begin
            if (!m.h2[i] == m.st[i]) begin
                m.run[i] = 16'd0;
            end else begin
                m.run[i] = m.run[i] + 16'd1;
                if (m.run[i] >= 16'(d)) begin
                    m.st[i]  = ~m.st[i];
                    m.run[i] = 16'd0;
                end
            end
        end
        m.h2 = m.h1;
        m.h1 = bn;
        return m;
    endfunction

    // Model: steps on each rising edge; an asynchronous reset clears it and
    // drops anything not yet compared.
    always @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            m2 = model_reset();
            m3 = model_reset();
        end else begin
            m2 = model_step(m2, int'(N2), int'(D2), {1'b1, btn_n2}, mode2);
            m3 = model_step(m3, int'(N3), int'(D3), btn_n3, mode3);
        end
        if (clk) begin
            q2.push_back({m2.st, m2.led, m2.rise});
            q3.push_back({m3.st, m3.led, m3.rise});
        end else begin
            q2.delete();
            q3.delete();
        end
    end

    task automatic check(input string name, input logic [2:0] got,
                         input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
        end
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin
        logic [4:0] e;
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("dut2 btn_state", {1'b0, st2}, {1'b0, e[3:2]});
            check("dut2 led_0", {2'b00, led2}, {2'b00, e[1]});
            check("dut2 led_rise", {2'b00, rise2}, {2'b00, e[0]});
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check("dut3 btn_state", st3, e[4:2]);
            check("dut3 led_0", {2'b00, led3}, {2'b00, e[1]});
            check("dut3 led_rise", {2'b00, rise3}, {2'b00, e[0]});
        end
    end

    // Advance n falling edges, landing just after each so inputs change
    // well away from the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with buttons held, then release.
        tick(5);
        rst_btn = 1'b1;
        btn_n3  = 3'b000;
        tick(8);
        btn_n3  = 3'b001;
        tick(6);

        // Bounce rejection on channel 0, channel 1 held pressed.
        btn_n2 = 2'b01; tick(10);
        btn_n2 = 2'b00; tick(3);
        btn_n2 = 2'b01; tick(1);
        btn_n2 = 2'b00; tick(2);
        btn_n2 = 2'b01; tick(4);
        btn_n2 = 2'b00; tick(10);

        // Mode sweep with only channel 0 pressed.
        btn_n2 = 2'b10; tick(10);
        for (int k = 0; k < 4; k++) begin
            mode2 = 2'(k);
            tick(3);
        end

        // Release path in AND mode.
        mode2  = 2'd0;
        btn_n2 = 2'b00; tick(10);
        btn_n2 = 2'b10; tick(10);

        // Asynchronous reset while channel 0's release is mid-count.
        btn_n2 = 2'b00; tick(10);
        btn_n2 = 2'b01; tick(4);
        #2;
        rst_btn = 1'b0;
        #1;
        check("async rst btn_state", {1'b0, st2}, 3'b000);
        check("async rst led_0", {2'b00, led2}, 3'b000);
        check("async rst led_rise", {2'b00, rise2}, 3'b000);
        check("async rst dut3 btn_state", st3, 3'b000);
        tick(2);
        rst_btn = 1'b1;
        tick(12);

        // Randomised traffic with occasional mode changes and resets.
        repeat (80) begin
            btn_n2 = 2'($urandom);
            btn_n3 = 3'($urandom);
            if ($urandom_range(0, 3) == 0) mode2 = 2'($urandom);
            if ($urandom_range(0, 3) == 0) mode3 = 2'($urandom);
            tick(int'($urandom_range(1, 9)));
            if ($urandom_range(0, 24) == 0) begin
                rst_btn = 1'b0;
                tick(2);
                rst_btn = 1'b1;
            end
        end
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
